// File: rtl/crc32_frame_sequencer.sv
// rtl/crc32_frame_sequencer.sv - beat-to-bit front end feeding a serial CRC-32/MPEG-2 register.
// Optional receive-side residue check enabled with CRC32_SEQ_CHECK_EN (adds crc_ok_out).
module crc32_frame_sequencer #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  data_last_in,
    output logic                  data_ready_out,
    input  logic                  abort_in,
    output logic                  busy_out,
    output logic [31:0]           crc_out,
    output logic                  crc_valid_out
`ifdef CRC32_SEQ_CHECK_EN
    ,
    output logic                  crc_ok_out
`endif
);

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           crc_q, crc_d;
    logic [31:0]           crc_out_q, crc_out_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  ready;
    logic                  xfer;
    logic                  final_bit;
    logic [31:0]           crc_bit;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[31];
        return {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    endfunction

`ifdef CRC32_SEQ_CHECK_EN
    logic ok_q, ok_d;
`endif

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
`ifdef CRC32_SEQ_CHECK_EN
        ok_d      = ok_q;
`endif
        crc_bit   = crc_step(crc_q, shift_q[DATA_WIDTH-1]);
        final_bit = (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE:  ready = 1'b1;
            ST_WAIT:  ready = 1'b1;
            ST_SHIFT: ready = final_bit && !last_q;
            default:  ready = 1'b0;
        endcase
        if (abort_in) begin
            ready = 1'b0;
        end
        xfer = data_valid_in && ready;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    crc_d   = CRC_INIT;
                    shift_d = data_in;
                    last_d  = data_last_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                crc_d   = crc_bit;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (final_bit) begin
                    cnt_d = '0;
                    if (last_q) begin
                        crc_out_d = crc_bit;
`ifdef CRC32_SEQ_CHECK_EN
                        ok_d      = (crc_bit == 32'h0);
`endif
                        state_d   = ST_DONE;
                    end else if (xfer) begin
                        shift_d = data_in;
                        last_d  = data_last_in;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (xfer) begin
                    shift_d = data_in;
                    last_d  = data_last_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort drops the open frame; an idle block has nothing to discard.
        if (abort_in && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            crc_d     = CRC_INIT;
            crc_out_d = crc_out_q;
            cnt_d     = '0;
            last_d    = 1'b0;
`ifdef CRC32_SEQ_CHECK_EN
            ok_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            crc_q     <= CRC_INIT;
            crc_out_q <= 32'h0;
            shift_q   <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

`ifdef CRC32_SEQ_CHECK_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ok_q <= 1'b0;
        end else begin
            ok_q <= ok_d;
        end
    end
    assign crc_ok_out = ok_q;
`endif

    assign data_ready_out = ready;
    assign busy_out       = (state_q != ST_IDLE);
    assign crc_out        = crc_out_q;
    assign crc_valid_out  = (state_q == ST_DONE);

endmodule

// File: tb/tb_crc32_frame_sequencer.sv
// tb/tb_crc32_frame_sequencer.sv - self-checking bench for crc32_frame_sequencer.
module tb_crc32_frame_sequencer;

    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] CHECK = 32'h0376E6E7;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  data_in;
    logic        data_valid_in;
    logic        data_last_in;
    logic        data_ready_out;
    logic        abort_in;
    logic        busy_out;
    logic [31:0] crc_out;
    logic        crc_valid_out;
`ifdef CRC32_SEQ_CHECK_EN
    logic        crc_ok_out;
`endif

    crc32_frame_sequencer #(.DATA_WIDTH(8), .CRC_INIT(32'hFFFF_FFFF)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .data_last_in   (data_last_in),
        .data_ready_out (data_ready_out),
        .abort_in       (abort_in),
        .busy_out       (busy_out),
        .crc_out        (crc_out),
        .crc_valid_out  (crc_valid_out)
`ifdef CRC32_SEQ_CHECK_EN
        ,
        .crc_ok_out     (crc_ok_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [31:0] pulse_crc[$];
    int          pulse_cyc[$];
    int          acc_cyc[$];
    logic [7:0]  frame_q[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (crc_valid_out) begin
            pulse_crc.push_back(crc_out);
            pulse_cyc.push_back(cyc);
        end
    end

    // Byte-at-a-time reference: fold the byte into the top, then eight polynomial shifts.
    function automatic logic [31:0] model_crc();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (frame_q[i]) begin
            c = c ^ {frame_q[i], 24'h0};
            for (int k = 0; k < 8; k++) begin
                c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_check_frame();
        frame_q.delete();
        for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int t;
        data_in       = d;
        data_valid_in = 1'b1;
        data_last_in  = last;
        #1;
        t = 0;
        while (!data_ready_out && t < 100) begin
            tick();
            t++;
        end
        tests_run++;
        if (!data_ready_out) begin
            tests_failed++;
            $display("FAIL accept_timeout ready=%0b after %0d cycles, required 1", data_ready_out, t);
        end
        acc_cyc.push_back(cyc);
        tick();
        data_valid_in = 1'b0;
        data_last_in  = 1'($urandom_range(0, 1));
        data_in       = 8'($urandom);
    endtask

    // gap = idle cycles offered after the previous beat has fully shifted out.
    task automatic send_frame(input int gap);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i > 0 && gap > 0) begin
                repeat (8 + gap) begin
                    tick();
                    tests_run++;
                    if (busy_out !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL busy_in_gap busy=%0b, required 1", busy_out);
                    end
                end
            end
            send_beat(frame_q[i], i == frame_q.size() - 1);
        end
    endtask

    task automatic wait_pulse(input int target);
        int t;
        t = 0;
        while (pulse_crc.size() < target && t < 400) begin
            tick();
            t++;
        end
        tests_run++;
        if (pulse_crc.size() < target) begin
            tests_failed++;
            $display("FAIL pulse_timeout pulses=%0d, required %0d", pulse_crc.size(), target);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;
        #1;
        tests_run++;
        if ({data_ready_out, busy_out, crc_valid_out} !== 3'b100 || crc_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state rdy/busy/vld=%b crc=%h, required 100 crc=00000000",
                     {data_ready_out, busy_out, crc_valid_out}, crc_out);
        end
    endtask

    task automatic test_single();
        int n0;
        n0 = pulse_crc.size();
        acc_cyc.delete();
        load_check_frame();
        send_frame(0);
        wait_pulse(n0 + 1);
        repeat (5) tick();
        tests_run++;
        if (pulse_crc.size() != n0 + 1) begin
            tests_failed++;
            $display("FAIL single_pulse_count pulses=%0d, required %0d", pulse_crc.size(), n0 + 1);
        end
        if (pulse_crc.size() > n0) begin
            tests_run++;
            if (pulse_crc[n0] !== CHECK) begin
                tests_failed++;
                $display("FAIL single_crc got=%h, required %h", pulse_crc[n0], CHECK);
            end
            tests_run++;
            if (pulse_cyc[n0] - acc_cyc[0] != 73) begin
                tests_failed++;
                $display("FAIL single_latency got=%0d, required 73", pulse_cyc[n0] - acc_cyc[0]);
            end
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            tests_run++;
            if (acc_cyc[i] - acc_cyc[i-1] != 8) begin
                tests_failed++;
                $display("FAIL ready_spacing beat%0d got=%0d, required 8", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_wait();
        int n0;
        n0 = pulse_crc.size();
        load_check_frame();
        send_frame(5);
        wait_pulse(n0 + 1);
        if (pulse_crc.size() > n0) begin
            tests_run++;
            if (pulse_crc[n0] !== CHECK) begin
                tests_failed++;
                $display("FAIL wait_crc got=%h, required %h", pulse_crc[n0], CHECK);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = pulse_crc.size();
        load_check_frame();
        send_frame(0);
        send_frame(0);
        wait_pulse(n0 + 2);
        for (int i = 0; i < 2; i++) begin
            if (pulse_crc.size() > n0 + i) begin
                tests_run++;
                if (pulse_crc[n0+i] !== CHECK) begin
                    tests_failed++;
                    $display("FAIL b2b_crc frame%0d got=%h, required %h", i, pulse_crc[n0+i], CHECK);
                end
            end
        end
    endtask

    task automatic test_abort();
        int n0;
        n0 = pulse_crc.size();
        load_check_frame();
        for (int i = 0; i < 4; i++) send_beat(frame_q[i], 1'b0);
        repeat (3) tick();
        abort_in      = 1'b1;
        data_valid_in = 1'b1;
        data_in       = 8'h35;
        #1;
        tests_run++;
        if (data_ready_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_ready ready=%0b, required 0", data_ready_out);
        end
        tick();
        abort_in      = 1'b0;
        data_valid_in = 1'b0;
        #1;
        tests_run++;
        if (busy_out !== 1'b0 || crc_out !== CHECK) begin
            tests_failed++;
            $display("FAIL abort_state busy=%0b crc=%h, required 0 %h", busy_out, crc_out, CHECK);
        end
        repeat (80) tick();
        tests_run++;
        if (pulse_crc.size() != n0) begin
            tests_failed++;
            $display("FAIL abort_no_pulse pulses=%0d, required %0d", pulse_crc.size(), n0);
        end
        send_frame(0);
        wait_pulse(n0 + 1);
        if (pulse_crc.size() > n0) begin
            tests_run++;
            if (pulse_crc[n0] !== CHECK) begin
                tests_failed++;
                $display("FAIL abort_next_crc got=%h, required %h", pulse_crc[n0], CHECK);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n0;
        n0 = pulse_crc.size();
        load_check_frame();
        send_beat(frame_q[0], 1'b0);
        send_beat(frame_q[1], 1'b0);
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tests_run++;
        if ({data_ready_out, busy_out, crc_valid_out} !== 3'b100 || crc_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_state rdy/busy/vld=%b crc=%h, required 100 crc=00000000",
                     {data_ready_out, busy_out, crc_valid_out}, crc_out);
        end
        n0 = pulse_crc.size();
        send_frame(0);
        wait_pulse(n0 + 1);
        if (pulse_crc.size() > n0) begin
            tests_run++;
            if (pulse_crc[n0] !== CHECK) begin
                tests_failed++;
                $display("FAIL midreset_crc got=%h, required %h", pulse_crc[n0], CHECK);
            end
        end
    endtask

    task automatic test_random();
        int n0;
        logic [31:0] exp;
        for (int f = 0; f < 20; f++) begin
            frame_q.delete();
            repeat ($urandom_range(1, 12)) frame_q.push_back(8'($urandom));
            exp = model_crc();
            n0  = pulse_crc.size();
            send_frame($urandom_range(0, 6));
            wait_pulse(n0 + 1);
            if (pulse_crc.size() > n0) begin
                tests_run++;
                if (pulse_crc[n0] !== exp) begin
                    tests_failed++;
                    $display("FAIL random_crc frame%0d len=%0d got=%h, required %h",
                             f, frame_q.size(), pulse_crc[n0], exp);
                end
            end
            repeat ($urandom_range(0, 4)) tick();
        end
    endtask

`ifdef CRC32_SEQ_CHECK_EN
    task automatic test_check();
        int n0;
        for (int k = 0; k < 2; k++) begin
            load_check_frame();
            frame_q.push_back(8'h03);
            frame_q.push_back(8'h76);
            frame_q.push_back(8'hE6);
            frame_q.push_back(k == 0 ? 8'hE7 : 8'hE6);
            n0 = pulse_crc.size();
            send_frame(0);
            wait_pulse(n0 + 1);
            if (pulse_crc.size() > n0) begin
                tests_run++;
                if (pulse_crc[n0] !== model_crc() || crc_ok_out !== (k == 0)) begin
                    tests_failed++;
                    $display("FAIL check_residue case%0d crc=%h ok=%0b, required %h %0b",
                             k, pulse_crc[n0], crc_ok_out, model_crc(), (k == 0));
                end
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in        = 1'b1;
        data_in       = 8'h00;
        data_valid_in = 1'b0;
        data_last_in  = 1'b0;
        abort_in      = 1'b0;
        test_reset();
        test_single();
        test_wait();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        test_random();
`ifdef CRC32_SEQ_CHECK_EN
        test_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/crc32_frame_sequencer.md
Name: crc32_frame_sequencer

Overview:
- Byte-stream front end for the bit-serial CRC-32/MPEG-2 datapath.
- Accepts beats over a valid/ready handshake and shifts each beat MSB-first, one bit per clock, into an internal bit-serial CRC-32/MPEG-2 register.
- Frames are delimited with a last flag. At end of frame it presents the 32-bit CRC with a one-cycle valid pulse.
- Sits between the packet/byte source and the transport framer that appends or checks the CRC.

Parameters:
- DATA_WIDTH, 8: bits per input beat, shifted MSB-first; legal range 1..32.
- CRC_INIT, 32'hFFFF_FFFF: value loaded into the CRC register at frame start.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous, active-high reset.
- data_in, input, DATA_WIDTH: beat payload.
- data_valid_in, input, 1: beat valid.
- data_last_in, input, 1: beat is the final beat of the frame; qualified by data_valid_in.
- data_ready_out, output, 1: block can accept a beat this cycle.
- abort_in, input, 1: discard the current frame.
- busy_out, output, 1: high from first-beat accept until DONE or abort.
- crc_out, output, 32: CRC of the last completed frame; held stable.
- crc_valid_out, output, 1: one-cycle pulse when crc_out is updated.

Behaviour:
- Clocking/reset: one clock, clk_in. Reset rst_in is synchronous, active-high.
- Reset values: state=IDLE, data_ready_out=1, busy_out=0, crc_out=32'h0, crc_valid_out=0, internal CRC reg=CRC_INIT, bit counter=0.
- CRC arithmetic:
  - Polynomial 0x04C11DB7, MSB-first, no reflection, no final XOR.
  - Per bit b: fb = b ^ crc[31]; crc = {crc[30:0],1'b0} ^ (fb ? 0x04C11DB7 : 0).
- Handshake: a beat transfers when data_valid_in && data_ready_out. Data is held in a shift register; the source may change data_in after transfer.
- States:
  - IDLE: no frame open. ready=1. On transfer: CRC reg <= CRC_INIT, load shift reg, latch last, cnt<=0, busy=1, go to SHIFT.
  - SHIFT: one bit per cycle, MSB first; cnt increments.
    - At cnt==DATA_WIDTH-1 (final bit): if last latched, go to DONE.
    - Otherwise ready=1 this cycle only. On transfer, load the next beat, cnt<=0, stay in SHIFT (back-to-back, DATA_WIDTH cycles per beat). With no transfer, go to WAIT.
    - ready=0 on all other SHIFT cycles.
  - WAIT: frame open, shift idle. ready=1. On transfer, load the beat and go to SHIFT. The CRC reg is NOT reinitialised.
  - DONE: crc_out <= CRC reg, crc_valid_out=1 for exactly this cycle, busy=0 next cycle, go to IDLE. ready=0 in DONE.
- Latency: the final bit of the last beat is processed in SHIFT cycle N. DONE is cycle N+1, and crc_out is visible with crc_valid_out in cycle N+1.
- abort_in:
  - Highest priority below reset, in any state. Next state is IDLE, CRC reg <= CRC_INIT, busy=0, no crc_valid pulse, crc_out unchanged.
  - A beat offered in the same cycle is not accepted: ready is forced 0 while abort_in=1.
- abort in IDLE: no effect.
- rst_in mid-frame: all state discarded, reset values above.
- data_last_in is ignored unless a transfer occurs.
- A frame is always ≥1 beat; zero-length frames cannot be expressed.

Optional Feature:
- Macro: CRC32_SEQ_CHECK_EN.
- Defined:
  - Adds output crc_ok_out (1 bit, reset 0). It updates in DONE with (CRC reg == 32'h0000_0000) and is valid alongside crc_valid_out.
  - This is the receive-side check for a frame carrying its own CRC appended big-endian, which yields residue 0.
  - crc_ok_out holds until the next DONE. Abort and reset clear it to 0.
- Undefined: the port does not exist and no compare logic is built. All other behaviour is identical.

Test Plan:
- Single frame, ASCII "123456789" (0x31..0x39), valid held high, last on 0x39 -> one crc_valid_out pulse with crc_out=32'h0376E6E7 exactly 73 cycles after the first accept. data_ready_out pulses once every 8 cycles.
- Same frame with valid deasserted 5 cycles between beats (WAIT exercised) -> identical crc_out=32'h0376E6E7; busy_out high throughout.
- Two back-to-back frames, "123456789" then "123456789" -> two pulses, both 32'h0376E6E7, confirming re-init at frame start.
- abort_in asserted during the 4th beat's SHIFT, then a full "123456789" frame -> no pulse for the aborted frame, next pulse 32'h0376E6E7. crc_out holds its prior value across the abort.
- rst_in asserted mid-SHIFT -> next cycle ready=1, busy=0, crc_valid_out=0, crc_out=0. A subsequent frame computes correctly.
- CRC32_SEQ_CHECK_EN: frame "123456789",0x03,0x76,0xE6,0xE7 -> crc_out=0, crc_ok_out=1. Corrupt the final byte to 0xE6 -> crc_ok_out=0.
